// File: rtl/core_sequencer_if.sv
// Handshake/control bundle between the sequencer and the core datapath.
// slave: sequencer side; master: datapath/stimulus side.
interface core_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  start;
  logic                  step;
  logic                  halt_req;
  logic [DATA_WIDTH-1:0] instruction;
  logic                  alu_zero;
  logic                  ir_we;
  logic                  pc_we;
  logic                  pc_sel;
  logic [1:0]            imm_sel;
  logic                  alusrc;
  logic                  wb_sel;
  logic                  regwrite;
  logic                  busy;
  logic                  halted;
  logic                  illegal;
  logic [CNT_WIDTH-1:0]  retired;

  modport master (
    output start, step, halt_req,
    output instruction, alu_zero,
    input  ir_we, pc_we, pc_sel,
    input  imm_sel, alusrc, wb_sel,
    input  regwrite, busy, halted,
    input  illegal, retired
  );

  modport slave (
    input  start, step, halt_req,
    input  instruction, alu_zero,
    output ir_we, pc_we, pc_sel,
    output imm_sel, alusrc, wb_sel,
    output regwrite, busy, halted,
    output illegal, retired
  );
endinterface

// File: rtl/core_sequencer.sv
// Multicycle FETCH/DECODE/EXECUTE/WRITEBACK control for ADDI/ADD/BEQ/JAL.
// Ports: clk, rst (sync, active-high), bus (core_sequencer_if.slave).
module core_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int DIR_WIDTH  = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  core_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT,
    S_ERR
  } state_t;

  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t                 st_q, st_d;
  logic [6:0]             opc_q;
  logic [DIR_WIDTH-1:0]   rd_q;
  logic                   step_q;
  logic                   pend_q;
  logic                   taken_q;
  logic                   ill_q;
  logic [CNT_WIDTH-1:0]   ret_q;
  logic [DATA_WIDTH-1:0]  ins;

  logic is_addi, is_add, is_beq, is_jal;
  logic legal, in_op, is_busy, ctl;

  assign ins     = bus.instruction;
  assign is_addi = (opc_q == OP_ADDI);
  assign is_add  = (opc_q == OP_ADD);
  assign is_beq  = (opc_q == OP_BEQ);
  assign is_jal  = (opc_q == OP_JAL);
  assign legal   = is_addi | is_add | is_beq | is_jal;

  assign in_op   = (st_q == S_DECODE) ||
                   (st_q == S_EXEC)   ||
                   (st_q == S_WB);
  assign is_busy = in_op || (st_q == S_FETCH);
  assign ctl     = (st_q == S_IDLE) || (st_q == S_HALT);

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      S_IDLE, S_HALT:
        if (bus.step || bus.start) st_d = S_FETCH;
      S_FETCH:  st_d = S_DECODE;
      S_DECODE: st_d = legal ? S_EXEC : S_ERR;
      S_EXEC:   st_d = S_WB;
      // halt_req seen in WB itself is honoured at this boundary
      S_WB:
        st_d = (pend_q || bus.halt_req || step_q)
             ? S_HALT : S_FETCH;
      S_ERR:    st_d = S_ERR;
      default:  st_d = S_IDLE;
    endcase
  end

  // Outputs depend only on state and internal registers.
  always_comb begin
    bus.ir_we    = (st_q == S_FETCH);
    bus.pc_we    = (st_q == S_WB);
    bus.pc_sel   = 1'b0;
    bus.imm_sel  = 2'b00;
    bus.alusrc   = 1'b0;
    bus.wb_sel   = 1'b0;
    bus.regwrite = 1'b0;
    bus.busy     = is_busy;
    bus.halted   = (st_q == S_HALT);
    bus.illegal  = ill_q;
    bus.retired  = ret_q;
    if (in_op) begin
      unique case (1'b1)
        is_addi: bus.alusrc  = 1'b1;
        is_beq:  bus.imm_sel = 2'b01;
        is_jal: begin
          bus.imm_sel = 2'b10;
          bus.wb_sel  = 1'b1;
        end
        default: ;
      endcase
    end
    if (st_q == S_WB) begin
      bus.pc_sel   = is_jal | (is_beq & taken_q);
      bus.regwrite = (is_addi | is_add | is_jal) &&
                     (rd_q != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= S_IDLE;
      opc_q   <= '0;
      rd_q    <= '0;
      step_q  <= 1'b0;
      pend_q  <= 1'b0;
      taken_q <= 1'b0;
      ill_q   <= 1'b0;
      ret_q   <= '0;
    end else begin
      st_q <= st_d;
      if (st_q == S_FETCH) begin
        opc_q <= ins[6:0];
        rd_q  <= ins[7 +: DIR_WIDTH];
      end
      if (ctl && bus.step)
        step_q <= 1'b1;
      else if (ctl && bus.start)
        step_q <= 1'b0;
      if (st_d == S_HALT && st_q != S_HALT)
        pend_q <= 1'b0;
      else if (is_busy && bus.halt_req)
        pend_q <= 1'b1;
      if (st_q == S_EXEC && is_beq)
        taken_q <= bus.alu_zero;
      if (st_q == S_DECODE && !legal)
        ill_q <= 1'b1;
      if (st_q == S_WB)
        ret_q <= ret_q + 1'b1;
    end
  end

endmodule
